// File: rtl/irq_ack_decoder.sv
// irq_ack_decoder
//
// Receiving end of an 8-line priority encoder. A 3-bit code {y0,y1,y2}
// (y0 = MSB) is taken through a valid/ready handshake and turned into a
// registered one-hot acknowledge on a0..a7, where line index = 7 - code.
// The acknowledge is held for ACK_CYCLES cycles. An idle gap of GAP_CYCLES
// cycles follows before the next code is accepted. Completed acknowledges
// are counted mod 256.
//
// Parameters
//   ACK_CYCLES  cycles each acknowledge is held (1..15)
//   GAP_CYCLES  idle cycles after an acknowledge before ready returns (0..15)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   valid        code on y0..y2 is valid this cycle
//   y0, y1, y2   encoded request line, y0 = MSB
//   ready        block can accept a code this cycle (IDLE only)
//   a0..a7       registered one-hot acknowledge, a0 <-> code 111
//   busy         high in ACK or GAP
//   done         one-cycle pulse in the cycle after an acknowledge ends
//   count        completed acknowledges, mod 256
//
// State table
//   state  | meaning
//   S_IDLE | ready for a code, all acknowledges low
//   S_ACK  | one acknowledge line held high, timer counts the hold time
//   S_GAP  | acknowledges low, timer counts the enforced idle gap

module irq_ack_decoder #(
   parameter int unsigned ACK_CYCLES = 4,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       valid,
   input  logic       y0,
   input  logic       y1,
   input  logic       y2,
   output logic       ready,
   output logic       a0,
   output logic       a1,
   output logic       a2,
   output logic       a3,
   output logic       a4,
   output logic       a5,
   output logic       a6,
   output logic       a7,
   output logic       busy,
   output logic       done,
   output logic [7:0] count
);

   // Timer load values. The timer is a terminal-count down-counter: a load
   // of N-1 gives N cycles in the state before the exit at timer == 0.
   localparam logic [3:0] ACK_LOAD = 4'(ACK_CYCLES - 1);
   localparam logic [3:0] GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0
                                                       : 4'(GAP_CYCLES - 1);
   localparam logic       HAS_GAP  = (GAP_CYCLES != 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACK  = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] timer;
   logic [3:0] timer_nxt;
   logic [7:0] ack;
   logic [7:0] ack_nxt;
   logic       done_nxt;
   logic [7:0] count_nxt;

   logic [2:0] code;
   logic [2:0] line_idx;

   assign code     = {y0, y1, y2};
   // 7 - code over 3 bits is simply the bitwise complement.
   assign line_idx = ~code;

   // ------------------------------------------------------------------
   // Next-state and next-output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      ack_nxt   = ack;
      done_nxt  = 1'b0;
      count_nxt = count;

      case (state)
         S_IDLE: begin
            timer_nxt = 4'd0;
            ack_nxt   = 8'h00;
            if (valid) begin
               ack_nxt   = 8'h01 << line_idx;
               timer_nxt = ACK_LOAD;
               state_nxt = S_ACK;
            end
         end

         S_ACK: begin
            // Inputs are deliberately ignored here; the captured line is
            // held in ack until the timer expires.
            if (timer != 4'd0) begin
               timer_nxt = timer - 4'd1;
            end else begin
               ack_nxt   = 8'h00;
               done_nxt  = 1'b1;
               count_nxt = count + 8'd1;
               if (HAS_GAP) begin
                  timer_nxt = GAP_LOAD;
                  state_nxt = S_GAP;
               end else begin
                  // The done cycle itself is the all-zero separation
                  // between consecutive acknowledges.
                  timer_nxt = 4'd0;
                  state_nxt = S_IDLE;
               end
            end
         end

         S_GAP: begin
            ack_nxt = 8'h00;
            if (timer == 4'd0) begin
               state_nxt = S_IDLE;
            end else begin
               timer_nxt = timer - 4'd1;
            end
         end

         default: begin
            state_nxt = S_IDLE;
            timer_nxt = 4'd0;
            ack_nxt   = 8'h00;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         // An aborted acknowledge is neither counted nor signalled.
         state <= S_IDLE;
         timer <= 4'd0;
         ack   <= 8'h00;
         done  <= 1'b0;
         count <= 8'h00;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
         ack   <= ack_nxt;
         done  <= done_nxt;
         count <= count_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Decoded outputs
   // ------------------------------------------------------------------
   assign ready = (state == S_IDLE);
   assign busy  = (state == S_ACK) || (state == S_GAP);

   assign a0 = ack[0];
   assign a1 = ack[1];
   assign a2 = ack[2];
   assign a3 = ack[3];
   assign a4 = ack[4];
   assign a5 = ack[5];
   assign a6 = ack[6];
   assign a7 = ack[7];

endmodule

// File: tb/tb_irq_ack_decoder.sv
// tb_irq_ack_decoder
//
// Directed bench for irq_ack_decoder. Two instances are used:
//   u_dut_a  ACK_CYCLES=4, GAP_CYCLES=1  (single accept, sweep, busy,
//                                         mid-ACK reset, count wrap)
//   u_dut_b  ACK_CYCLES=1, GAP_CYCLES=0  (back-to-back with valid held)
// Inputs change 1 time unit after the rising edge; outputs are sampled there.

module tb_irq_ack_decoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance A stimulus / observation
   logic       rst_a   = 1'b1;
   logic       valid_a = 1'b0;
   logic [2:0] code_a  = 3'b000;
   logic       ready_a, busy_a, done_a;
   logic [7:0] count_a;
   logic       a0_a, a1_a, a2_a, a3_a, a4_a, a5_a, a6_a, a7_a;
   logic [7:0] ack_a;
   assign ack_a = {a7_a, a6_a, a5_a, a4_a, a3_a, a2_a, a1_a, a0_a};

   // instance B stimulus / observation
   logic       rst_b2   = 1'b1;
   logic       valid_b  = 1'b0;
   logic [2:0] code_b   = 3'b000;
   logic       ready_b, busy_b, done_b;
   logic [7:0] count_b;
   logic       a0_b, a1_b, a2_b, a3_b, a4_b, a5_b, a6_b, a7_b;
   logic [7:0] ack_b;
   assign ack_b = {a7_b, a6_b, a5_b, a4_b, a3_b, a2_b, a1_b, a0_b};

   irq_ack_decoder #(.ACK_CYCLES(4), .GAP_CYCLES(1)) u_dut_a (
      .clk   (clk),
      .rst   (rst_a),
      .valid (valid_a),
      .y0    (code_a[2]),
      .y1    (code_a[1]),
      .y2    (code_a[0]),
      .ready (ready_a),
      .a0    (a0_a), .a1 (a1_a), .a2 (a2_a), .a3 (a3_a),
      .a4    (a4_a), .a5 (a5_a), .a6 (a6_a), .a7 (a7_a),
      .busy  (busy_a),
      .done  (done_a),
      .count (count_a)
   );

   irq_ack_decoder #(.ACK_CYCLES(1), .GAP_CYCLES(0)) u_dut_b (
      .clk   (clk),
      .rst   (rst_b2),
      .valid (valid_b),
      .y0    (code_b[2]),
      .y1    (code_b[1]),
      .y2    (code_b[0]),
      .ready (ready_b),
      .a0    (a0_b), .a1 (a1_b), .a2 (a2_b), .a3 (a3_b),
      .a4    (a4_b), .a5 (a5_b), .a6 (a6_b), .a7 (a7_b),
      .busy  (busy_b),
      .done  (done_b),
      .count (count_b)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_a();
      rst_a   = 1'b1;
      valid_a = 1'b0;
      step();
      step();
      rst_a = 1'b0;
   endtask

   task automatic wait_ready_a();
      int n = 0;
      while (!ready_a && n < 100) begin
         step();
         n++;
      end
      check("ready_timeout", 32'(ready_a), 32'd1);
   endtask

   // Accept 111 from IDLE and check cycles 1..8 against the timing diagram.
   task automatic run_single(input string tag, input logic [7:0] c0);
      valid_a = 1'b1;
      code_a  = 3'b111;
      step();
      valid_a = 1'b0;
      for (int cyc = 1; cyc <= 8; cyc++) begin
         check({tag, "_a"},     32'(ack_a),   (cyc <= 4) ? 32'h01 : 32'h00);
         check({tag, "_done"},  32'(done_a),  (cyc == 5) ? 32'd1 : 32'd0);
         check({tag, "_ready"}, 32'(ready_a), (cyc >= 6) ? 32'd1 : 32'd0);
         check({tag, "_count"}, 32'(count_a),
               (cyc >= 5) ? 32'(8'(c0 + 8'd1)) : 32'(c0));
         step();
      end
   endtask

   // Accept a code and check the full ACK window against a given one-hot.
   task automatic serve_a(input string tag, input logic [2:0] code,
                          input logic [7:0] exp);
      wait_ready_a();
      valid_a = 1'b1;
      code_a  = code;
      step();
      valid_a = 1'b0;
      for (int cyc = 1; cyc <= 4; cyc++) begin
         check({tag, "_a"}, 32'(ack_a), 32'(exp));
         step();
      end
      check({tag, "_a_end"}, 32'(ack_a), 32'h00);
      check({tag, "_done"},  32'(done_a), 32'd1);
      step();
   endtask

   // Accept a code and return in the done cycle.
   task automatic serve_quiet(input logic [2:0] code);
      int n = 0;
      wait_ready_a();
      valid_a = 1'b1;
      code_a  = code;
      step();
      valid_a = 1'b0;
      while (!done_a && n < 50) begin
         step();
         n++;
      end
      check("done_timeout", 32'(done_a), 32'd1);
   endtask

   logic [7:0] sweep_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                 8'h10, 8'h20, 8'h40, 8'h80};

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- reset values ----------------
      reset_a();
      check("rst_ready", 32'(ready_a), 32'd1);
      check("rst_busy",  32'(busy_a),  32'd0);
      check("rst_ack",   32'(ack_a),   32'h00);
      check("rst_done",  32'(done_a),  32'd0);
      check("rst_count", 32'(count_a), 32'h00);

      // ---------------- single accept ----------------
      run_single("single", 8'd0);

      // ---------------- full decode sweep ----------------
      reset_a();
      for (int i = 0; i < 8; i++) begin
         serve_a("sweep", 3'(7 - i), sweep_exp[i]);
      end
      check("sweep_count", 32'(count_a), 32'd8);

      // ---------------- inputs ignored while busy ----------------
      reset_a();
      wait_ready_a();
      valid_a = 1'b1;
      code_a  = 3'b100;
      step();
      for (int cyc = 1; cyc <= 5; cyc++) begin
         valid_a = cyc[0];
         code_a  = 3'(cyc * 3);
         check("busy_a",     32'(ack_a),   (cyc <= 4) ? 32'h08 : 32'h00);
         check("busy_ready", 32'(ready_a), 32'd0);
         check("busy_busy",  32'(busy_a),  32'd1);
         step();
      end
      valid_a = 1'b0;
      check("busy_ready_back", 32'(ready_a), 32'd1);
      check("busy_ack6",       32'(ack_a),   32'h00);
      check("busy_count",      32'(count_a), 32'd1);
      step();
      check("busy_ack7",       32'(ack_a),   32'h00);

      // ---------------- reset mid-acknowledge ----------------
      reset_a();
      for (int i = 0; i < 5; i++) serve_quiet(3'(i));
      check("mid_pre_count", 32'(count_a), 32'd5);
      wait_ready_a();
      valid_a = 1'b1;
      code_a  = 3'b011;
      step();
      valid_a = 1'b0;
      check("mid_c1_a", 32'(ack_a), 32'h10);
      step();
      check("mid_c2_a", 32'(ack_a), 32'h10);
      rst_a = 1'b1;
      valid_a = 1'b1;
      step();
      rst_a = 1'b0;
      valid_a = 1'b0;
      check("mid_rst_a",     32'(ack_a),   32'h00);
      check("mid_rst_count", 32'(count_a), 32'h00);
      check("mid_rst_ready", 32'(ready_a), 32'd1);
      check("mid_rst_busy",  32'(busy_a),  32'd0);
      check("mid_rst_done",  32'(done_a),  32'd0);
      for (int cyc = 0; cyc < 6; cyc++) begin
         step();
         check("mid_no_done",  32'(done_a),  32'd0);
         check("mid_no_count", 32'(count_a), 32'h00);
      end
      run_single("mid_after", 8'd0);

      // ---------------- count wrap ----------------
      reset_a();
      for (int i = 1; i <= 256; i++) begin
         serve_quiet(3'(i));
         if (i == 255) check("wrap_255", 32'(count_a), 32'd255);
         if (i == 256) check("wrap_256", 32'(count_a), 32'd0);
      end

      // ---------------- back-to-back, GAP=0, ACK=1 ----------------
      rst_b2 = 1'b1;
      step();
      step();
      rst_b2 = 1'b0;
      check("b2b_rst_ready", 32'(ready_b), 32'd1);
      check("b2b_rst_ack",   32'(ack_b),   32'h00);
      valid_b = 1'b1;
      code_b  = 3'b101;
      step();
      code_b  = 3'b010;
      check("b2b_c1_a",     32'(ack_b),   32'h04);
      check("b2b_c1_ready", 32'(ready_b), 32'd0);
      check("b2b_c1_busy",  32'(busy_b),  32'd1);
      step();
      check("b2b_c2_a",     32'(ack_b),   32'h00);
      check("b2b_c2_done",  32'(done_b),  32'd1);
      check("b2b_c2_ready", 32'(ready_b), 32'd1);
      check("b2b_c2_count", 32'(count_b), 32'd1);
      step();
      valid_b = 1'b0;
      check("b2b_c3_a",     32'(ack_b),   32'h20);
      check("b2b_c3_done",  32'(done_b),  32'd0);
      step();
      check("b2b_c4_a",     32'(ack_b),   32'h00);
      check("b2b_c4_done",  32'(done_b),  32'd1);
      check("b2b_c4_count", 32'(count_b), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/irq_ack_decoder.md
# irq_ack_decoder

Sequential 3-to-8 acknowledge decoder that sits at the receiving end of the 8-line priority encoder. It accepts the encoder's 3-bit code {y0,y1,y2} (y0 = MSB) through a valid/ready handshake. It drives a one-hot acknowledge back to the selected request line for a programmable number of cycles, then enforces a programmable idle gap before accepting the next code. It also counts served acknowledges.

## Interface
- ACK_CYCLES, 4: cycles each one-hot acknowledge is held; legal 1..15.
- GAP_CYCLES, 1: idle cycles after an acknowledge before `ready` returns; legal 0..15.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- valid  in  1  code on y0..y2 is valid this cycle.
- y0, y1, y2  in  1 each  encoded line; y0 MSB; line index = 7 − {y0,y1,y2} (111→a0, 000→a7).
- ready  out  1  block can accept a code this cycle.
- a0..a7  out  1 each  registered one-hot acknowledge; a0 corresponds to code 111.
- busy  out  1  high in ACK or GAP state.
- done  out  1  one-cycle pulse after an acknowledge ends.
- count  out  8  number of completed acknowledges, mod 256.

## Operation
- States: IDLE, ACK, GAP. A 4-bit down-counter `timer` serves both ACK and GAP.
- IDLE:
  - ready=1, busy=0, a0..a7=0.
  - valid & ready at an edge: capture idx = 7 − {y0,y1,y2}, set a[idx]=1, timer=ACK_CYCLES−1, go to ACK.
  - valid=0: stay in IDLE.
- ACK:
  - ready=0, busy=1, exactly one a output high. y0..y2 and valid are ignored.
  - timer≠0: decrement timer.
  - timer==0 at an edge:
    - clear all a outputs.
    - pulse done for the next cycle.
    - count ← count+1 (wraps 255→0).
    - GAP_CYCLES==0: go to IDLE.
    - otherwise: timer=GAP_CYCLES−1, go to GAP.
- GAP:
  - ready=0, busy=1, a outputs=0.
  - timer==0 at an edge: go to IDLE. Otherwise decrement timer.
- `ready` is decoded from state (high only in IDLE). `done`, `count` and a0..a7 are registers.
- Reset (rst=1 at an edge), at any state including mid-ACK/GAP:
  - next cycle: state IDLE, a0..a7=0, done=0, count=0, timer=0, ready=1, busy=0.
  - no done pulse and no count increment for the aborted acknowledge.
- While rst is high, valid is ignored; no capture occurs on a reset edge.
- Code 000 is a legal code and selects a7. The block makes no distinction between "line 7" and "no request"; the upstream source gates that with valid.

## Timing
- Handshake accepted at edge E0 (cycle 0). a[idx] is high in cycles 1..ACK_CYCLES.
- done is high in cycle ACK_CYCLES+1 only. count shows the new value from cycle ACK_CYCLES+1.
- ready rises in cycle ACK_CYCLES+1+GAP_CYCLES.
- Minimum accept-to-accept spacing: ACK_CYCLES+1+GAP_CYCLES cycles.
  - Even with GAP_CYCLES=0, consecutive acknowledges are separated by at least one all-zero cycle.
  - With GAP_CYCLES=0, the done pulse and ready=1 coincide.
- valid held high continuously is accepted at each cycle where ready=1. The code sampled is the one present at that edge.
- A code change while ready=0 has no effect.
- Reset values: ready=1, busy=0, done=0, a0..a7=0, count=0x00.

## Test plan
- Reset then single accept:
  - ACK_CYCLES=4, GAP_CYCLES=1; valid=1, {y0,y1,y2}=111 for one cycle at E0.
  - Required: a0=1 in cycles 1–4, all a low otherwise; done=1 in cycle 5 only; count=1 from cycle 5; ready=1 from cycle 6.
- Full decode sweep:
  - Apply codes 111→000 one per accept.
  - Required: codes drive a0..a7 respectively, exactly one a high in each ACK window; count=8 at end.
- Back-to-back with GAP_CYCLES=0, ACK_CYCLES=1, valid held high:
  - codes 101 then 010 (code 010 presented while ready=0).
  - Required: a2 high in cycle 1, all low in cycle 2 (done=1, ready=1), a5 high in cycle 3.
- Ignored input while busy:
  - During ACK for code 100 (a3), toggle valid and the code every cycle.
  - Required: only a3 high for the full window; no second accept until ready returns.
- Reset mid-acknowledge:
  - rst=1 in cycle 2 of a 4-cycle ACK with count=5.
  - Required: next cycle all a=0, count=0, done never pulses, ready=1; a new accept afterward behaves as in the first scenario.
- Count wrap:
  - Perform 256 acknowledges.
  - Required: count reads 255 after the 255th, 0 after the 256th.
